bsg_link_ds_core_arb: RTL and testbench
=======================================

BSG_LINK_DS_CORE_ARB -- requirements
Module: bsg_link_ds_core_arb

Interface
REQ-001 Parameter NUM_CH, default 2, number of downstream channels sharing the core-side consumer; legal range 2..8.
REQ-002 Parameter CH_WIDTH, default 32, data width of each channel.
REQ-003 Parameter ID_WIDTH, default 3, width of the channel-id output; the block SHALL require 2**ID_WIDTH >= NUM_CH.
REQ-004 The block SHALL have one clock; reset is synchronous and active-high.
REQ-005 The ports SHALL be as follows:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  synchronous active-high reset.
- ch_valid_i  in  NUM_CH  per-channel data-valid from the downstream channels.
- ch_data_i  in  NUM_CH*CH_WIDTH  channel c data at bits [c*CH_WIDTH +: CH_WIDTH].
- ch_yumi_o  out  NUM_CH  per-channel dequeue; combinational, one-hot or zero.
- pause_i  in  1  when 1, no new grants; the output register still drains.
- out_valid_o  out  1  output register holds a word.
- out_data_o  out  CH_WIDTH  registered word.
- out_ch_o  out  ID_WIDTH  channel index of the registered word.
- out_ready_i  in  1  consumer accepts the word when out_valid_o=1.
- xfer_cnt_o  out  16  count of accepted output words; wraps 0xFFFF->0.
- idle_o  out  1  1 when out_valid_o=0 and ch_valid_i is all-zero.

Function
REQ-010 The handshake SHALL be valid-then-yumi: ch_yumi_o[c] asserts only when ch_valid_i[c]=1, and ch_yumi_o[c] SHALL never depend on itself.
REQ-011 Define load = ~rst & ~pause_i & (~out_valid_o | out_ready_i).
REQ-012 When load=1 and any ch_valid_i bit is set, the grant g SHALL be the first valid channel found searching upward from rr_ptr, wrapping modulo NUM_CH.
REQ-013 On a grant, ch_yumi_o[g] SHALL be 1 in the same cycle; on the next edge out_valid_o<=1, out_data_o<=ch_data_i[g], out_ch_o<=g, and rr_ptr<=(g+1) mod NUM_CH.
REQ-014 When load=1 and no channel is valid, ch_yumi_o SHALL be 0 and rr_ptr SHALL hold. If out_ready_i=1 and out_valid_o=1, out_valid_o<=0 and out_data_o/out_ch_o hold.
REQ-015 When load=0, ch_yumi_o SHALL be 0 and rr_ptr SHALL hold. out_valid_o, out_data_o and out_ch_o SHALL hold unless an output accept (REQ-018) clears out_valid_o.
REQ-016 Back-to-back throughput SHALL be one word per cycle: an accept and a new grant in the same cycle replace the register contents with no bubble.
REQ-017 Latency SHALL be 1 cycle from grant (yumi) to out_valid_o.
REQ-018 An output accept is out_valid_o & out_ready_i; on each accept, xfer_cnt_o SHALL increment by 1 modulo 2**16.
REQ-019 An accept while pause_i=1 SHALL clear out_valid_o and increment xfer_cnt_o; no grant SHALL issue that cycle.
REQ-020 rr_ptr SHALL be ID_WIDTH bits and always satisfy rr_ptr < NUM_CH; the wrap from NUM_CH-1 SHALL go to 0, including when NUM_CH is not a power of two.
REQ-021 Fairness: with all channels continuously valid and out_ready_i=1, each channel SHALL be granted exactly once in every NUM_CH consecutive grants.
REQ-022 Idle-to-busy: when out_valid_o=0 and a channel becomes valid (pause_i=0), its yumi SHALL assert in that same cycle.
REQ-023 out_data_o and out_ch_o SHALL be stable while out_valid_o=1 and out_ready_i=0.
REQ-024 ch_data_i of non-granted channels SHALL not affect any state.

Reset
REQ-030 While rst=1: out_valid_o=0, out_data_o=0, out_ch_o=0, rr_ptr=0, xfer_cnt_o=0, and ch_yumi_o=0 (gated combinationally).
REQ-031 Reset asserted mid-transfer SHALL discard the held word without an accept count; the first cycle after reset SHALL be able to grant channel 0 if it is valid.
REQ-032 idle_o SHALL follow its REQ-005 definition during reset.

Verification
REQ-040 Continuous traffic: ch_valid_i=2'b11, out_ready_i=1, data ch0=0xA0+n, ch1=0xB0+n -> yumi alternates ch0,ch1,ch0,...; out_ch_o 0,1,0,...; one word per cycle; xfer_cnt_o=8 after 8 accepts.
REQ-041 Backpressure: out_ready_i=0 for 3 cycles with out_valid_o=1 -> ch_yumi_o=0, out_data_o unchanged; on release, a new grant occurs the same cycle.
REQ-042 Single requester: only ch1 valid (NUM_CH=3), then ch0 and ch2 valid -> grants ch1, then ch2, then ch0 (rr_ptr wraps 2->0).
REQ-043 Pause: pause_i=1 with a word held and out_ready_i=1 -> word accepted, out_valid_o=0, no yumi until pause_i=0.
REQ-044 Reset mid-operation: rst=1 for 1 cycle while out_valid_o=1 and xfer_cnt_o=5 -> all outputs 0, xfer_cnt_o=0; the next grant goes to ch0.
REQ-045 Counter wrap: force 0xFFFF accepts -> xfer_cnt_o=0xFFFF; the next accept gives 0x0000.

Source files
------------

// File: rtl/bsg_link_ds_core_arb.sv
// Round-robin arbiter merging NUM_CH downstream channels into one registered output word.
// Grants use valid-then-yumi, and an accept plus a new grant in the same cycle sustains one word per cycle.
module bsg_link_ds_core_arb #(
  parameter int unsigned NUM_CH   = 2,
  parameter int unsigned CH_WIDTH = 32,
  parameter int unsigned ID_WIDTH = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH-1:0]            ch_valid_i,
  input  logic [NUM_CH*CH_WIDTH-1:0]   ch_data_i,
  output logic [NUM_CH-1:0]            ch_yumi_o,
  input  logic                         pause_i,
  output logic                         out_valid_o,
  output logic [CH_WIDTH-1:0]          out_data_o,
  output logic [ID_WIDTH-1:0]          out_ch_o,
  input  logic                         out_ready_i,
  output logic [15:0]                  xfer_cnt_o,
  output logic                         idle_o
);

  localparam int unsigned CNT_W = 16;

  logic [ID_WIDTH-1:0] r_rr_ptr;
  logic                r_out_valid;
  logic [CH_WIDTH-1:0] r_out_data;
  logic [ID_WIDTH-1:0] r_out_ch;
  logic [CNT_W-1:0]    r_xfer_cnt;

  logic                w_load;
  logic                w_accept;
  logic                w_found;
  logic                w_grant;
  logic [NUM_CH-1:0]   w_sel;
  logic [ID_WIDTH-1:0] w_gnt_idx;
  logic [CH_WIDTH-1:0] w_gnt_data;
  logic [ID_WIDTH-1:0] w_ptr_nxt;

  assign w_load   = ~rst & ~pause_i & (~r_out_valid | out_ready_i);
  assign w_accept = r_out_valid & out_ready_i;

  // First valid channel at or above rr_ptr, otherwise first valid channel below it.
  always_comb begin
    w_found    = 1'b0;
    w_sel      = '0;
    w_gnt_idx  = '0;
    w_gnt_data = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (!w_found && ch_valid_i[c] && (ID_WIDTH'(c) >= r_rr_ptr)) begin
        w_found    = 1'b1;
        w_sel[c]   = 1'b1;
        w_gnt_idx  = ID_WIDTH'(c);
        w_gnt_data = ch_data_i[c*CH_WIDTH +: CH_WIDTH];
      end
    end
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (!w_found && ch_valid_i[c]) begin
        w_found    = 1'b1;
        w_sel[c]   = 1'b1;
        w_gnt_idx  = ID_WIDTH'(c);
        w_gnt_data = ch_data_i[c*CH_WIDTH +: CH_WIDTH];
      end
    end
  end

  assign w_grant   = w_load & w_found;
  assign w_ptr_nxt = (w_gnt_idx == ID_WIDTH'(NUM_CH - 1)) ? '0 : w_gnt_idx + ID_WIDTH'(1);

  // Output register, pointer and accept counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr    <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ch    <= '0;
      r_xfer_cnt  <= '0;
    end else begin
      if (w_grant) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_gnt_data;
        r_out_ch    <= w_gnt_idx;
        r_rr_ptr    <= w_ptr_nxt;
      end else if (w_accept) begin
        r_out_valid <= 1'b0;
      end
      if (w_accept) begin
        r_xfer_cnt <= r_xfer_cnt + CNT_W'(1);
      end
    end
  end

  assign ch_yumi_o   = w_grant ? w_sel : '0;
  assign out_valid_o = r_out_valid;
  assign out_data_o  = r_out_data;
  assign out_ch_o    = r_out_ch;
  assign xfer_cnt_o  = r_xfer_cnt;
  assign idle_o      = ~r_out_valid & ~(|ch_valid_i);

endmodule

// File: tb/tb_bsg_link_ds_core_arb.sv
// Directed bench for bsg_link_ds_core_arb with three channels (non-power-of-two pointer wrap).
module tb_bsg_link_ds_core_arb;

  localparam int unsigned NUM_CH   = 3;
  localparam int unsigned CH_WIDTH = 32;
  localparam int unsigned ID_WIDTH = 2;

  logic                       clk;
  logic                       rst;
  logic [NUM_CH-1:0]          ch_valid_i;
  logic [NUM_CH*CH_WIDTH-1:0] ch_data_i;
  logic [NUM_CH-1:0]          ch_yumi_o;
  logic                       pause_i;
  logic                       out_valid_o;
  logic [CH_WIDTH-1:0]        out_data_o;
  logic [ID_WIDTH-1:0]        out_ch_o;
  logic                       out_ready_i;
  logic [15:0]                xfer_cnt_o;
  logic                       idle_o;

  int n_total = 0;
  int n_bad   = 0;

  bsg_link_ds_core_arb #(
    .NUM_CH   (NUM_CH),
    .CH_WIDTH (CH_WIDTH),
    .ID_WIDTH (ID_WIDTH)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .ch_valid_i  (ch_valid_i),
    .ch_data_i   (ch_data_i),
    .ch_yumi_o   (ch_yumi_o),
    .pause_i     (pause_i),
    .out_valid_o (out_valid_o),
    .out_data_o  (out_data_o),
    .out_ch_o    (out_ch_o),
    .out_ready_i (out_ready_i),
    .xfer_cnt_o  (xfer_cnt_o),
    .idle_o      (idle_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2);
    ch_data_i = {d2, d1, d0};
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [31:0] d, input logic [1:0] c);
    chk({tag, "_valid"}, 32'(out_valid_o), 32'(v));
    chk({tag, "_data"}, out_data_o, d);
    chk({tag, "_ch"}, 32'(out_ch_o), 32'(c));
  endtask

  initial begin
    rst         = 1'b1;
    ch_valid_i  = 3'b111;
    pause_i     = 1'b0;
    out_ready_i = 1'b1;
    set_data(32'h1, 32'h2, 32'h3);

    // Reset state, yumi gated while in reset.
    tick();
    chk_out("rst", 1'b0, 32'h0, 2'd0);
    chk("rst_xfer", 32'(xfer_cnt_o), 32'd0);
    chk("rst_yumi", 32'(ch_yumi_o), 32'd0);
    chk("rst_idle_busy", 32'(idle_o), 32'd0);
    ch_valid_i = 3'b000;
    #1;
    chk("rst_idle", 32'(idle_o), 32'd1);

    // Continuous traffic on ch0/ch1.
    rst        = 1'b0;
    ch_valid_i = 3'b011;
    for (int n = 0; n < 8; n++) begin
      set_data(32'hA0 + 32'(n), 32'hB0 + 32'(n), 32'hDEAD);
      #1;
      chk("cont_yumi", 32'(ch_yumi_o), (n % 2 == 0) ? 32'd1 : 32'd2);
      tick();
      chk_out("cont", 1'b1, (n % 2 == 0) ? 32'hA0 + 32'(n) : 32'hB0 + 32'(n), 2'(n % 2));
      chk("cont_xfer", 32'(xfer_cnt_o), 32'(n));
    end
    ch_valid_i = 3'b000;
    #1;
    chk("drain_yumi", 32'(ch_yumi_o), 32'd0);
    tick();
    chk("drain_xfer", 32'(xfer_cnt_o), 32'd8);
    chk_out("drain", 1'b0, 32'hB7, 2'd1);
    chk("drain_idle", 32'(idle_o), 32'd1);

    // Backpressure: rr_ptr is 2, so ch0 wins first.
    ch_valid_i = 3'b011;
    set_data(32'h11, 32'h22, 32'h0);
    #1;
    chk("bp_yumi0", 32'(ch_yumi_o), 32'd1);
    tick();
    chk_out("bp_first", 1'b1, 32'h11, 2'd0);
    out_ready_i = 1'b0;
    set_data(32'h99, 32'h22, 32'h0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_stall_yumi", 32'(ch_yumi_o), 32'd0);
      tick();
      chk_out("bp_stall", 1'b1, 32'h11, 2'd0);
    end
    out_ready_i = 1'b1;
    #1;
    chk("bp_release_yumi", 32'(ch_yumi_o), 32'd2);
    tick();
    chk_out("bp_release", 1'b1, 32'h22, 2'd1);
    chk("bp_xfer", 32'(xfer_cnt_o), 32'd9);
    ch_valid_i = 3'b000;
    tick();
    chk("bp_drain_xfer", 32'(xfer_cnt_o), 32'd10);

    // Single requester then wrap 2->0.
    ch_valid_i = 3'b010;
    set_data(32'h40, 32'h31, 32'h42);
    #1;
    chk("rr_yumi1", 32'(ch_yumi_o), 32'd2);
    tick();
    chk_out("rr_ch1", 1'b1, 32'h31, 2'd1);
    ch_valid_i = 3'b101;
    #1;
    chk("rr_yumi2", 32'(ch_yumi_o), 32'd4);
    tick();
    chk_out("rr_ch2", 1'b1, 32'h42, 2'd2);
    #1;
    chk("rr_yumi0", 32'(ch_yumi_o), 32'd1);
    tick();
    chk_out("rr_ch0", 1'b1, 32'h40, 2'd0);
    chk("rr_xfer", 32'(xfer_cnt_o), 32'd12);
    ch_valid_i = 3'b000;
    tick();
    chk("rr_drain_xfer", 32'(xfer_cnt_o), 32'd13);

    // Pause: held word drains, no grants until pause drops.
    ch_valid_i = 3'b001;
    set_data(32'h55, 32'h66, 32'h77);
    #1;
    chk("pause_pre_yumi", 32'(ch_yumi_o), 32'd1);
    tick();
    chk_out("pause_pre", 1'b1, 32'h55, 2'd0);
    pause_i    = 1'b1;
    ch_valid_i = 3'b111;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("pause_yumi", 32'(ch_yumi_o), 32'd0);
      tick();
      chk_out("pause_hold", 1'b0, 32'h55, 2'd0);
      chk("pause_xfer", 32'(xfer_cnt_o), 32'd14);
    end
    pause_i = 1'b0;
    #1;
    chk("unpause_yumi", 32'(ch_yumi_o), 32'd2);
    tick();
    chk_out("unpause", 1'b1, 32'h66, 2'd1);
    chk("unpause_xfer", 32'(xfer_cnt_o), 32'd14);

    // Reset mid-operation with xfer_cnt at 5.
    rst        = 1'b1;
    ch_valid_i = 3'b000;
    tick();
    rst        = 1'b0;
    ch_valid_i = 3'b001;
    for (int i = 0; i < 6; i++) begin
      set_data(32'h70 + 32'(i), 32'h0, 32'h0);
      tick();
    end
    chk("mid_pre_xfer", 32'(xfer_cnt_o), 32'd5);
    chk_out("mid_pre", 1'b1, 32'h75, 2'd0);
    rst        = 1'b1;
    ch_valid_i = 3'b111;
    #1;
    chk("mid_rst_yumi", 32'(ch_yumi_o), 32'd0);
    tick();
    chk_out("mid_rst", 1'b0, 32'h0, 2'd0);
    chk("mid_rst_xfer", 32'(xfer_cnt_o), 32'd0);
    rst = 1'b0;
    set_data(32'h80, 32'h81, 32'h82);
    #1;
    chk("post_rst_yumi", 32'(ch_yumi_o), 32'd1);
    tick();
    chk_out("post_rst", 1'b1, 32'h80, 2'd0);
    chk("post_rst_xfer", 32'(xfer_cnt_o), 32'd0);

    // Accept counter wrap.
    rst = 1'b1;
    tick();
    rst        = 1'b0;
    ch_valid_i = 3'b001;
    repeat (65536) tick();
    chk("wrap_ffff", 32'(xfer_cnt_o), 32'h0000FFFF);
    tick();
    chk("wrap_zero", 32'(xfer_cnt_o), 32'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
